// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped UART transmitter with a byte FIFO.
// DATA at BASE_ADDRESS (store pushes a byte), STATUS at BASE_ADDRESS+4.
// Ports: clk24/rst (async active-high), memory_address, memory_write_value,
//   memory_write_sections (store bus), read_value/read_selected (registered
//   read port), uart_tx (serial line, idle high), irq (level interrupt).
// Optional macro UART_TX_IRQ_EN enables irq_enable and the irq output.
module uart_tx_peripheral #(
    parameter logic [31:0] BASE_ADDRESS = 32'h80000018,
    parameter int          CLKS_PER_BIT = 208,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk24,
    input  logic        rst,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_value,
    input  logic [3:0]  memory_write_sections,
    output logic [31:0] read_value,
    output logic        read_selected,
    output logic        uart_tx,
    output logic        irq
);

    localparam int          AW             = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST      = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    logic        overflow;
    logic        irq_enable;

    logic        data_hit;
    logic        status_hit;
    logic        fifo_empty;
    logic        fifo_full;
    logic        baud_done;
    logic        busy;
    logic        push_req;
    logic        push;
    logic        pop;
    logic [31:0] count_ext;
    logic [3:0]  count_sat;
    logic [31:0] status_word;
    logic        unused_bits;

    assign data_hit   = memory_address[31:2] == BASE_ADDRESS[31:2];
    assign status_hit = memory_address[31:2] == STATUS_ADDRESS[31:2];
    assign fifo_empty = count == '0;
    assign fifo_full  = count == (AW+1)'(FIFO_DEPTH);
    assign baud_done  = baud_cnt == BAUD_LAST;
    assign busy       = state != IDLE;

    // The FSM takes a byte whenever it is ready for a new frame.
    assign pop = ((state == IDLE) || ((state == STOP) && baud_done))
                 && !fifo_empty;

    // A push into a full FIFO still fits if a pop frees a slot this cycle.
    assign push_req = data_hit && memory_write_sections[0];
    assign push     = push_req && (!fifo_full || pop);

    assign count_ext = 32'(count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    assign status_word = {20'b0, count_sat, 3'b0, irq_enable,
                          overflow, busy, fifo_full, fifo_empty};

    assign unused_bits = ^{memory_address[1:0], memory_write_sections[3:1],
                           memory_write_value[31:8], memory_write_value[4]};

    always_ff @(posedge clk24) begin
        if (push) begin
            fifo_mem[wr_ptr] <= memory_write_value[7:0];
        end
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (status_hit && memory_write_sections[0]
                     && memory_write_value[3]) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            irq_enable <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (status_hit && memory_write_sections[0]) begin
                irq_enable <= memory_write_value[4];
            end
            irq <= irq_enable && fifo_empty && (state == IDLE);
        end
    end
`else
    assign irq_enable = 1'b0;
    assign irq        = 1'b0;
`endif

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift   <= fifo_mem[rd_ptr];
                        state   <= START;
                        uart_tx <= 1'b0;
                    end else begin
                        uart_tx <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Chain straight into the next frame when data waits.
                        if (pop) begin
                            shift   <= fifo_mem[rd_ptr];
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            read_selected <= 1'b0;
            read_value    <= '0;
        end else if (status_hit) begin
            read_selected <= 1'b1;
            read_value    <= status_word;
        end else if (data_hit) begin
            read_selected <= 1'b1;
            read_value    <= '0;
        end else begin
            read_selected <= 1'b0;
            read_value    <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb_uart_tx_peripheral: directed bench for uart_tx_peripheral
// with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
module tb_uart_tx_peripheral;

    localparam logic [31:0] BASE = 32'h80000018;
    localparam logic [31:0] STAT = 32'h8000001C;

    logic        clk24 = 1'b0;
    logic        rst;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic [3:0]  memory_write_sections;
    logic [31:0] read_value;
    logic        read_selected;
    logic        uart_tx;
    logic        irq;

    int total = 0;
    int bad   = 0;

    uart_tx_peripheral #(
        .BASE_ADDRESS(BASE),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(8)
    ) dut (
        .clk24(clk24),
        .rst(rst),
        .memory_address(memory_address),
        .memory_write_value(memory_write_value),
        .memory_write_sections(memory_write_sections),
        .read_value(read_value),
        .read_selected(read_selected),
        .uart_tx(uart_tx),
        .irq(irq)
    );

    always #5 clk24 = ~clk24;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        memory_address        = 32'h0;
        memory_write_value    = 32'h0;
        memory_write_sections = 4'b0000;
    endtask

    // Called at a negedge; the next posedge takes the store.
    task automatic store(input logic [31:0] addr, input logic [31:0] val);
        memory_address        = addr;
        memory_write_value    = val;
        memory_write_sections = 4'b0001;
        @(negedge clk24);
        bus_idle();
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic sel,
                            output logic [31:0] val);
        memory_address        = addr;
        memory_write_sections = 4'b0000;
        @(negedge clk24);
        sel = read_selected;
        val = read_value;
        bus_idle();
    endtask

    // Waits for a start bit, then checks all 4 samples of each of the
    // 10 bit periods; returns on the last stop-bit sample.
    task automatic recv(input logic [7:0] exp, output int waited);
        logic [3:0] s;
        logic       e;
        waited = 0;
        do begin
            @(negedge clk24);
            waited++;
        end while (uart_tx !== 1'b0 && waited < 300);
        if (uart_tx !== 1'b0) begin
            check("rx_start", {31'b0, uart_tx}, 32'h0);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp[k-1];
            for (int j = 0; j < 4; j++) begin
                if (k != 0 || j != 0) @(negedge clk24);
                s[j] = uart_tx;
            end
            check("rx_bit", {16'b0, exp, k[3:0], s},
                  {16'b0, exp, k[3:0], {4{e}}});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sel;
        logic [31:0] v;
        int          w;
        int          lows;

        rst = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk24);
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_sel", {31'b0, read_selected}, 32'h0);
        check("rst_val", read_value, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk24);

        read_reg(STAT, sel, v);
        check("stat_sel", {31'b0, sel}, 32'h1);
        check("stat_idle", v, 32'h1);
        read_reg(32'h80000000, sel, v);
        check("miss_sel", {31'b0, sel}, 32'h0);
        check("miss_val", v, 32'h0);
        read_reg(BASE, sel, v);
        check("data_sel", {31'b0, sel}, 32'h1);
        check("data_val", v, 32'h0);
        read_reg(STAT + 32'd1, sel, v);
        check("stat_off_sel", {31'b0, sel}, 32'h1);
        check("stat_off_val", v, 32'h1);

        store(BASE, 32'h55);
        fork
            begin
                recv(8'h55, w);
                check("first_lat", w, 32'd1);
            end
            begin
                repeat (12) @(negedge clk24);
                read_reg(STAT, sel, v);
                check("busy_mid", {31'b0, v[2]}, 32'h1);
            end
        join
        repeat (2) @(negedge clk24);
        read_reg(STAT, sel, v);
        check("busy_after", v, 32'h1);

        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    memory_address        = BASE;
                    memory_write_value    = 32'(i);
                    memory_write_sections = 4'b0001;
                    @(negedge clk24);
                end
                bus_idle();
                read_reg(STAT, sel, v);
                check("ovf_full", v, 32'h0000080E);
            end
            begin
                for (int f = 0; f < 9; f++) begin
                    int wf;
                    recv(8'(f), wf);
                    if (f > 0) check("b2b_gap", wf, 32'd1);
                end
            end
        join
        repeat (2) @(negedge clk24);
        read_reg(STAT, sel, v);
        check("ovf_sticky", v, 32'h9);
        store(STAT, 32'h8);
        read_reg(STAT, sel, v);
        check("ovf_clear", v, 32'h1);

        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    memory_address        = BASE;
                    memory_write_value    = 32'h10 + 32'(i);
                    memory_write_sections = 4'b0001;
                    @(negedge clk24);
                end
                bus_idle();
                repeat (32) @(negedge clk24);
                store(BASE, 32'hA5);
                read_reg(STAT, sel, v);
                check("full_pop_push", v, 32'h00000806);
            end
            begin
                for (int f = 0; f < 10; f++) begin
                    int wf;
                    recv((f == 9) ? 8'hA5 : 8'(8'h10 + f), wf);
                    if (f > 0) check("pp_gap", wf, 32'd1);
                end
            end
        join
        repeat (2) @(negedge clk24);

        memory_address        = BASE;
        memory_write_value    = 32'hFF;
        memory_write_sections = 4'b0001;
        @(negedge clk24);
        memory_write_value    = 32'h00;
        @(negedge clk24);
        bus_idle();
        repeat (17) @(negedge clk24);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_mid_sel", {31'b0, read_selected}, 32'h0);
        repeat (2) @(negedge clk24);
        rst = 1'b0;
        @(negedge clk24);
        read_reg(STAT, sel, v);
        check("rst_status", v, 32'h1);
        lows = 0;
        repeat (60) begin
            @(negedge clk24);
            if (uart_tx !== 1'b1) lows++;
        end
        check("rst_quiet", lows, 32'd0);

`ifdef UART_TX_IRQ_EN
        store(STAT, 32'h10);
        repeat (2) @(negedge clk24);
        check("irq_idle", {31'b0, irq}, 32'h1);
        read_reg(STAT, sel, v);
        check("irq_en_rd", v, 32'h11);
        store(BASE, 32'h3C);
        fork
            recv(8'h3C, w);
            begin
                repeat (15) @(negedge clk24);
                check("irq_busy", {31'b0, irq}, 32'h0);
            end
        join
        @(negedge clk24);
        check("irq_stop0", {31'b0, irq}, 32'h0);
        @(negedge clk24);
        check("irq_stop1", {31'b0, irq}, 32'h1);
`else
        store(STAT, 32'h10);
        read_reg(STAT, sel, v);
        check("irq_off_rd", v, 32'h1);
        repeat (2) @(negedge clk24);
        check("irq_off", {31'b0, irq}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_peripheral.md
UART_TX_PERIPHERAL -- requirements
Module: uart_tx_peripheral

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h80000018, address of the DATA register; STATUS is at BASE_ADDRESS+4.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 208, the clk24 cycles per UART bit (≈115200 baud); legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, a power of two ≥2.
REQ-004 SHALL have port clk24  input  1  core clock; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port memory_address  input  32  core bus address.
REQ-007 SHALL have port memory_write_value  input  32  store data, already lane-shifted by byte offset.
REQ-008 SHALL have port memory_write_sections  input  4  byte-lane write enables; nonzero means a store this cycle, asserted for exactly one cycle per store.
REQ-009 SHALL have port read_value  output  32  registered read data.
REQ-010 SHALL have port read_selected  output  1  registered; 1 when read_value belongs to this block.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-012 SHALL have port irq  output  1  level interrupt (see Configuration).

Function
REQ-013 SHALL decode a register hit by comparing memory_address[31:2] with the register address[31:2].
REQ-014 SHALL give reads 1-cycle latency: read_value/read_selected SHALL update on the clk24 edge after the address is presented; on a miss, read_selected=0 and read_value=0.
REQ-015 SHALL have no read side effects.
REQ-016 DATA read SHALL return 0; a DATA store with lane 0 enabled SHALL push memory_write_value[7:0] into the FIFO.
REQ-017 STATUS read SHALL return: bit0 fifo_empty, bit1 fifo_full, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bit4 irq_enable, bits[11:8] fifo count (saturated to 15), all other bits 0.
REQ-018 A STATUS store with lane 0 enabled SHALL clear overflow if bit3=1 and load irq_enable from bit4.
REQ-019 A push while full SHALL drop the byte and set overflow, except when a pop occurs in the same cycle; the push SHALL then be accepted and count SHALL be unchanged.
REQ-020 The FIFO SHALL use wrapping read/write pointers of width log2(FIFO_DEPTH) plus a count of width log2(FIFO_DEPTH)+1; the pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-021 The FSM SHALL have four states, IDLE, START, DATA and STOP, with uart_tx registered from the state.
REQ-022 In IDLE, uart_tx SHALL be 1; when the FIFO is non-empty, the FSM SHALL pop into a shift register in that cycle and enter START.
REQ-023 In START, uart_tx SHALL be 0 for CLKS_PER_BIT cycles, after which the FSM SHALL enter DATA.
REQ-024 In DATA, the FSM SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7 it SHALL enter STOP.
REQ-025 In STOP, uart_tx SHALL be 1 for CLKS_PER_BIT cycles; the FSM SHALL then enter IDLE, or pop the next byte and enter START directly when the FIFO is non-empty (back-to-back frames, no extra idle cycles).
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on every state or bit change, and be 16 bits wide.
REQ-027 The first edge of uart_tx (the start bit) SHALL occur at most 2 clk24 cycles after the pushing store.

Reset
REQ-028 Asserting rst SHALL immediately force uart_tx=1, FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, irq_enable=0, read_selected=0, read_value=0, irq=0; a frame in progress SHALL be abandoned.
REQ-029 Deassertion SHALL be treated as synchronous to clk24 by the instantiating level; the block SHALL operate from the first edge after release.

Configuration
REQ-030 Macro UART_TX_IRQ_EN: when defined, irq SHALL be registered and equal irq_enable & fifo_empty & (FSM==IDLE).
REQ-031 Without UART_TX_IRQ_EN, irq SHALL be tied 0, STATUS bit4 SHALL read 0, and writes to bit4 SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-032 Store 0x55 to DATA → uart_tx shows 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles; STATUS busy=1 during the frame and busy=0 after.
REQ-033 Store 10 bytes 0x00..0x09 in consecutive cycles → 0x00 is popped at once and 0x01..0x08 fill the FIFO (full=1), so 0x09 is dropped and overflow=1; serial output is 0x00..0x08 back-to-back, and a STATUS store of 0x8 clears overflow.
REQ-034 With the FIFO full and a pop coinciding with a push of 0xA5 → overflow stays 0, count stays 8, and 0xA5 is transmitted last.
REQ-035 Assert rst during DATA bit 3 of 0xFF → uart_tx=1 in the same cycle, STATUS reads 0x00000001 after release, and no further frame is sent.
REQ-036 Read BASE_ADDRESS+4 at idle → on the next cycle read_selected=1 and read_value=0x00000001; read 0x80000000 → read_selected=0.
REQ-037 With UART_TX_IRQ_EN, store 0x10 to STATUS and then store one byte → irq falls while busy and rises 1 cycle after STOP completes.
